// File: rtl/reset_sequencer_if.sv
// Bundle of the reset sequencer's control inputs and sequenced outputs.
// master: the side that supplies lock/requests and observes the resets.
// slave:  the sequencer itself.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  locked;
  logic                  sw_reset_req;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  ready;
  logic [7:0]            seq_count;

  modport master (
    output locked,
    output sw_reset_req,
    input  rst_out,
    input  ready,
    input  seq_count
  );

  modport slave (
    input  locked,
    input  sw_reset_req,
    output rst_out,
    output ready,
    output seq_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all domain resets for HOLD_CYCLES, waits for a
// filtered PLL/MMCM lock, then releases NUM_STAGES resets one at a time
// (bit 0 first) spaced STAGE_GAP cycles apart. A software request, or a lock
// loss once release has begun, aborts and restarts the whole sequence.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_FILTER = 4,
  parameter int STAGE_GAP   = 8
) (
  input  logic             clk,
  input  logic             rst,
  reset_sequencer_if.slave bus
);

  localparam int MAX_A = (HOLD_CYCLES > LOCK_FILTER) ? HOLD_CYCLES : LOCK_FILTER;
  localparam int MAX_C = (MAX_A > STAGE_GAP) ? MAX_A : STAGE_GAP;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int IW    = $clog2(NUM_STAGES) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_READY     = 2'd3
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_rst_out;
  logic                  r_ready;
  logic [7:0]            r_seq_count;
  logic                  r_lock_meta;
  logic                  r_lock_sync;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [NUM_STAGES-1:0] w_rst_out_nxt;
  logic                  w_ready_nxt;
  logic [7:0]            w_seq_count_nxt;
  logic                  w_abort;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= bus.locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Lock loss only aborts once stages may already be out of reset.
  assign w_abort = bus.sw_reset_req |
                   (~r_lock_sync & ((r_state == ST_RELEASE) | (r_state == ST_READY)));

  // Next-state, counter and registered-output computation.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_rst_out_nxt   = r_rst_out;
    w_ready_nxt     = r_ready;
    w_seq_count_nxt = r_seq_count;

    if (w_abort) begin
      w_state_nxt   = ST_ASSERT;
      w_cnt_nxt     = '0;
      w_idx_nxt     = '0;
      w_rst_out_nxt = '1;
      w_ready_nxt   = 1'b0;
      if (r_seq_count != 8'hFF) begin
        w_seq_count_nxt = r_seq_count + 8'd1;
      end
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (!r_lock_sync) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == LOCK_LAST) begin
            w_state_nxt = ST_RELEASE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + IDX_ONE;
            // Decoded clear avoids a variable part-select wider than the vector.
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
              if (IW'(k) == r_idx) begin
                w_rst_out_nxt[k] = 1'b0;
              end
            end
            if (r_idx == IDX_LAST) begin
              w_state_nxt = ST_READY;
              w_ready_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_READY: begin
          w_rst_out_nxt = '0;
          w_ready_nxt   = 1'b1;
        end
        default: begin
          w_state_nxt   = ST_ASSERT;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_rst_out_nxt = '1;
          w_ready_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ASSERT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_out   <= '1;
      r_ready     <= 1'b0;
      r_seq_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_rst_out   <= w_rst_out_nxt;
      r_ready     <= w_ready_nxt;
      r_seq_count <= w_seq_count_nxt;
    end
  end

  assign bus.rst_out   = r_rst_out;
  assign bus.ready     = r_ready;
  assign bus.seq_count = r_seq_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
// Edge 1 is the first rising edge after rst is released; outputs are sampled
// 1 time unit after each rising edge.
module tb_reset_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   edge_n;

  reset_sequencer_if #(.NUM_STAGES(3)) bus ();

  reset_sequencer #(
    .NUM_STAGES (3),
    .HOLD_CYCLES(16),
    .LOCK_FILTER(4),
    .STAGE_GAP  (8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic goto_edge(input int e);
    step(e - edge_n);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    edge_n = 0;
    rst = 1'b1;
    bus.locked       = 1'b1;
    bus.sw_reset_req = 1'b0;

    // Test 1: lock already stable; releases at 28/36/44
    repeat (2) @(posedge clk);
    #1;
    chk("t1_reset_rst_out", 32'(bus.rst_out), 32'h7);
    chk("t1_reset_ready", 32'(bus.ready), 32'h0);
    chk("t1_reset_seq", 32'(bus.seq_count), 32'h0);
    apply_reset();
    goto_edge(27); chk("t1_e27_rst_out", 32'(bus.rst_out), 32'h7);
    goto_edge(28); chk("t1_e28_rst_out", 32'(bus.rst_out), 32'h6);
    goto_edge(35); chk("t1_e35_rst_out", 32'(bus.rst_out), 32'h6);
    goto_edge(36); chk("t1_e36_rst_out", 32'(bus.rst_out), 32'h4);
    goto_edge(43); chk("t1_e43_rst_out", 32'(bus.rst_out), 32'h4);
                   chk("t1_e43_ready", 32'(bus.ready), 32'h0);
    goto_edge(44); chk("t1_e44_rst_out", 32'(bus.rst_out), 32'h0);
                   chk("t1_e44_ready", 32'(bus.ready), 32'h1);
                   chk("t1_e44_seq", 32'(bus.seq_count), 32'h0);

    // Test 3: lock loss in READY, reasserts on the 3rd edge, then repeats
    goto_edge(50);
    bus.locked = 1'b0;
    goto_edge(52); chk("t3_e52_rst_out", 32'(bus.rst_out), 32'h0);
                   chk("t3_e52_ready", 32'(bus.ready), 32'h1);
    goto_edge(53); chk("t3_e53_rst_out", 32'(bus.rst_out), 32'h7);
                   chk("t3_e53_ready", 32'(bus.ready), 32'h0);
                   chk("t3_e53_seq", 32'(bus.seq_count), 32'h1);
    bus.locked = 1'b1;
    goto_edge(80); chk("t3_e80_rst_out", 32'(bus.rst_out), 32'h7);
    goto_edge(81); chk("t3_e81_rst_out", 32'(bus.rst_out), 32'h6);
    goto_edge(89); chk("t3_e89_rst_out", 32'(bus.rst_out), 32'h4);
                   chk("t3_e89_seq", 32'(bus.seq_count), 32'h1);

    // Test 4: sw pulse while rst_out=100; bit 0 falls 28 edges later
    goto_edge(92); chk("t4_e92_rst_out", 32'(bus.rst_out), 32'h4);
    bus.sw_reset_req = 1'b1;
    goto_edge(93);
    bus.sw_reset_req = 1'b0;
    chk("t4_e93_rst_out", 32'(bus.rst_out), 32'h7);
    chk("t4_e93_ready", 32'(bus.ready), 32'h0);
    chk("t4_e93_seq", 32'(bus.seq_count), 32'h2);
    goto_edge(120); chk("t4_e120_rst_out", 32'(bus.rst_out), 32'h7);
    goto_edge(121); chk("t4_e121_rst_out", 32'(bus.rst_out), 32'h6);
    goto_edge(137); chk("t4_e137_rst_out", 32'(bus.rst_out), 32'h0);
                    chk("t4_e137_ready", 32'(bus.ready), 32'h1);

    // seq_count saturation with a request held for 260 edges
    bus.sw_reset_req = 1'b1;
    step(260);
    chk("sat_seq", 32'(bus.seq_count), 32'hFF);
    chk("sat_rst_out", 32'(bus.rst_out), 32'h7);
    bus.sw_reset_req = 1'b0;
    step(3);
    chk("sat_seq_hold", 32'(bus.seq_count), 32'hFF);

    // Test 2: lock arrives after edge 30; RELEASE entered at 36, bit 0 at 44
    bus.locked = 1'b0;
    apply_reset();
    chk("t2_seq_after_rst", 32'(bus.seq_count), 32'h0);
    goto_edge(30);
    bus.locked = 1'b1;
    goto_edge(43); chk("t2_e43_rst_out", 32'(bus.rst_out), 32'h7);
    goto_edge(44); chk("t2_e44_rst_out", 32'(bus.rst_out), 32'h6);
    goto_edge(59); chk("t2_e59_ready", 32'(bus.ready), 32'h0);
    goto_edge(60); chk("t2_e60_rst_out", 32'(bus.rst_out), 32'h0);
                   chk("t2_e60_ready", 32'(bus.ready), 32'h1);

    // Test 5: async rst mid-RELEASE clears without a clock edge
    goto_edge(62);
    bus.sw_reset_req = 1'b1;
    goto_edge(63);
    bus.sw_reset_req = 1'b0;
    chk("t5_e63_seq", 32'(bus.seq_count), 32'h1);
    goto_edge(95); chk("t5_e95_rst_out", 32'(bus.rst_out), 32'h6);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_rst_out", 32'(bus.rst_out), 32'h7);
    chk("t5_async_seq", 32'(bus.seq_count), 32'h0);
    chk("t5_async_ready", 32'(bus.ready), 32'h0);
    apply_reset();
    goto_edge(27); chk("t5_e27_rst_out", 32'(bus.rst_out), 32'h7);
    goto_edge(28); chk("t5_e28_rst_out", 32'(bus.rst_out), 32'h6);

    // Test 6: lock chatter (high 3, low 1) never satisfies the filter
    bus.locked = 1'b0;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      bus.locked = ((i % 4) != 3);
      step(1);
      if (i >= 20) chk("t6_rst_out", 32'(bus.rst_out), 32'h7);
    end
    chk("t6_ready", 32'(bus.ready), 32'h0);
    chk("t6_seq", 32'(bus.seq_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
